// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a sync FIFO read port into a valid/ready stream framed into fixed bursts
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FWFT_EN    = 0,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  burst_done
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic [1:0]            used;
  logic                  pop;
  logic                  push;

  // A read in flight already owns a buffer slot, so it counts toward the limit of 2.
  assign used       = occ_q + {1'b0, inflight_q};
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = head_q;
  assign pop        = m_valid & m_ready;
  assign m_last     = m_valid & (beat_cnt == LAST_CNT);
  assign fifo_rd_en = en & ~fifo_empty & ~rst &
                      ((used < 2'd2) | ((used == 2'd2) & pop));
  assign push       = (FWFT_EN != 0) ? fifo_rd_en : inflight_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      inflight_q <= (FWFT_EN == 0) ? fifo_rd_en : 1'b0;
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= fifo_dout;
          else               skid_q <= fifo_dout;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= skid_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the skid word advances first.
          if (occ_q == 2'd2) begin
            head_q <= skid_q;
            skid_q <= fifo_dout;
          end else begin
            head_q <= fifo_dout;
          end
        end
        default: ;
      endcase
      burst_done <= pop & m_last;
      if (pop) beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized scoreboard bench for standard and FWFT instances
module tb_fifo_stream_reader;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst, en, m_ready;
  logic [7:0] fdout [2];
  logic [1:0] fempty, rd, mv, ml, bd;
  logic [7:0] md [2];
  logic [1:0] bc [2];

  fifo_stream_reader #(.DATA_WIDTH(8), .FWFT_EN(0), .BURST_LEN(BL), .CNT_WIDTH(2)) u_std (
    .clk(clk), .rst(rst), .en(en), .fifo_dout(fdout[0]), .fifo_empty(fempty[0]),
    .fifo_rd_en(rd[0]), .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .m_last(ml[0]), .beat_cnt(bc[0]), .burst_done(bd[0]));

  fifo_stream_reader #(.DATA_WIDTH(8), .FWFT_EN(1), .BURST_LEN(BL), .CNT_WIDTH(2)) u_fwft (
    .clk(clk), .rst(rst), .en(en), .fifo_dout(fdout[1]), .fifo_empty(fempty[1]),
    .fifo_rd_en(rd[1]), .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .m_last(ml[1]), .beat_cnt(bc[1]), .burst_done(bd[1]));

  always #5 clk = ~clk;

  // Source FIFO contents and the words taken from it but not yet accepted downstream.
  logic [7:0] src [2][0:2047];
  int         swr [2], srd [2];
  logic [7:0] eqd [2][0:7];
  int         eqa [2][0:7];
  int         hd [2], tl [2], ecnt [2];
  logic       edone [2];
  logic       s_rd [2], s_pop [2], s_last [2], s_rst;
  logic       prev_stall [2], prev_last [2];
  logic [7:0] prev_data [2];
  int         first_rd [2], first_valid [2], first_acc [2], last_acc [2];
  int         acc_cnt [2], done_cnt [2];
  int         cyc, checks, errors;

  task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", tag, inst, cyc, obs, expv);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < 2; i++) fempty[i] = (srd[i] == swr[i]);
    fdout[1] = fempty[1] ? 8'h00 : src[1][srd[1]];
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 2; i++) begin
      if (swr[i] < 2040) begin
        src[i][swr[i]] = w;
        swr[i]++;
      end
    end
    drive_fifo();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      first_rd[i] = -1; first_valid[i] = -1; first_acc[i] = -1; last_acc[i] = -1;
      acc_cnt[i] = 0; done_cnt[i] = 0;
    end
  endtask

  task automatic step();
    int         used;
    logic       ev, epop, erd, elast;
    logic [7:0] ed, w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      used  = tl[i] - hd[i];
      ev    = (used != 0) && (eqa[i][hd[i] % 8] <= cyc);
      ed    = eqd[i][hd[i] % 8];
      epop  = ev & m_ready;
      elast = ev && (ecnt[i] == BL - 1);
      erd   = en & ~fempty[i] & ~rst & ((used < 2) | ((used == 2) & epop));
      a_cap: assert (used <= 2);
      check("outstanding_le2", i, (used <= 2), 1);
      check("rd_en", i, rd[i], erd);
      check("valid", i, mv[i], ev);
      if (ev) check("data", i, md[i], ed);
      check("last", i, ml[i], elast);
      check("beat_cnt", i, bc[i], ecnt[i]);
      check("burst_done", i, bd[i], edone[i]);
      if (prev_stall[i]) begin
        check("stall_valid", i, mv[i], 1);
        check("stall_data", i, md[i], prev_data[i]);
        check("stall_last", i, ml[i], prev_last[i]);
      end
      if (rd[i] && first_rd[i] < 0) first_rd[i] = cyc;
      if (mv[i] && first_valid[i] < 0) first_valid[i] = cyc;
      if (bd[i]) done_cnt[i]++;
      s_rd[i]       = erd;
      s_pop[i]      = epop;
      s_last[i]     = elast;
      prev_stall[i] = ev & ~m_ready & ~rst;
      prev_data[i]  = md[i];
      prev_last[i]  = ml[i];
    end
    s_rst = rst;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_rst) begin
        hd[i] = tl[i]; ecnt[i] = 0; edone[i] = 1'b0;
      end else begin
        edone[i] = s_pop[i] & s_last[i];
        if (s_pop[i]) begin
          hd[i]++;
          ecnt[i] = s_last[i] ? 0 : ecnt[i] + 1;
          acc_cnt[i]++;
          if (first_acc[i] < 0) first_acc[i] = cyc;
          last_acc[i] = cyc;
        end
        if (s_rd[i]) begin
          w = src[i][srd[i]];
          srd[i]++;
          eqd[i][tl[i] % 8] = w;
          eqa[i][tl[i] % 8] = cyc + ((i == 0) ? 2 : 1);
          tl[i]++;
          if (i == 0) fdout[0] = w;
        end
      end
    end
    cyc++;
    drive_fifo();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fdout[0] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      swr[i] = 0; srd[i] = 0; hd[i] = 0; tl[i] = 0; ecnt[i] = 0; edone[i] = 1'b0;
      prev_stall[i] = 1'b0; prev_last[i] = 1'b0; prev_data[i] = 8'h00;
    end
    drive_fifo();
    clear_stats();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_data", i, md[i], 0);
      check("rst_valid", i, mv[i], 0);
      check("rst_last", i, ml[i], 0);
      check("rst_cnt", i, bc[i], 0);
      check("rst_done", i, bd[i], 0);
    end

    // Back-to-back burst framing and first-beat latency.
    for (int k = 0; k < 8; k++) push_word(8'h10 + 8'(k));
    en = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 14; k++) step();
    for (int i = 0; i < 2; i++) begin
      check("latency", i, first_valid[i] - first_rd[i], (i == 0) ? 2 : 1);
      check("beats", i, acc_cnt[i], 8);
      check("bursts", i, done_cnt[i], 2);
      check("no_gaps", i, last_acc[i] - first_acc[i], 7);
    end

    // Backpressure with ready pattern 1,0,0.
    clear_stats();
    for (int k = 0; k < 8; k++) push_word(8'($urandom));
    for (int k = 0; k < 30; k++) begin
      m_ready = (k % 3 == 0);
      step();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    for (int i = 0; i < 2; i++) check("bp_beats", i, acc_cnt[i], 8);

    // Underflow gap in the middle of a burst.
    clear_stats();
    push_word(8'hA0); push_word(8'hA1);
    for (int k = 0; k < 7; k++) step();
    push_word(8'hA2); push_word(8'hA3);
    for (int k = 0; k < 6; k++) step();
    for (int i = 0; i < 2; i++) check("uf_bursts", i, done_cnt[i], 1);

    // en dropped while a read is in flight.
    push_word(8'hB0); push_word(8'hB1);
    for (int k = 0; k < 6; k++) step();
    for (int k = 0; k < 3; k++) push_word(8'hC0 + 8'(k));
    step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) step();
    en = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Reset mid-burst with the buffer full.
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_word(8'hD0 + 8'(k));
    step(); step(); m_ready = 1'b1; step(); m_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("mid_rst_valid", i, mv[i], 0);
      check("mid_rst_cnt", i, bc[i], 0);
      check("mid_rst_last", i, ml[i], 0);
      check("mid_rst_done", i, bd[i], 0);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      en      = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 0) push_word(8'($urandom));
      step();
    end
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side companion to the team's synchronous FIFO.
- Drains the FIFO read port (rd_en/dout/empty), in either standard (1-cycle read latency) or FWFT mode, and presents the words on a valid/ready stream with a 2-entry output buffer.
- Sustains one beat per clock and frames the stream into fixed-length bursts with a last marker.
- Sits between a syncFIFO instance and any valid/ready consumer (DMA packer, serializer).

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- FWFT_EN, 0, 1 = FIFO is FWFT (dout valid while ~empty, rd_en pops); 0 = standard FIFO (dout valid the cycle after rd_en).
- BURST_LEN, 16, beats per burst; must be >= 1.
- CNT_WIDTH, 4, beat counter width; must satisfy 2**CNT_WIDTH >= BURST_LEN.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  permits new FIFO reads; buffered and in-flight words still drain when low.
- fifo_dout  in  DATA_WIDTH  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe (combinational).
- m_data  out  DATA_WIDTH  stream data (registered).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  final beat of a burst.
- beat_cnt  out  CNT_WIDTH  accepted beats in the current burst.
- burst_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset state: buffer empty, in-flight flag 0, beat_cnt 0, m_valid 0, m_last 0, m_data 0, burst_done 0.
- fifo_rd_en is forced to 0 while rst is high.

Read issue:
- pop = m_valid & m_ready.
- used = occ + inflight, where occ is 0..2 buffered words and inflight is 0/1; inflight is always 0 when FWFT_EN=1.
- fifo_rd_en = en & ~fifo_empty & ~rst & (used < 2 | (used == 2 & pop)).
- fifo_rd_en is never asserted while fifo_empty = 1.

Capture:
- FWFT_EN=1: fifo_dout is written into the buffer at the same edge as the rd_en cycle.
- FWFT_EN=0: inflight is set at the rd_en edge; fifo_dout is written at the following edge, and inflight clears unless a new read is issued in that cycle.
- Buffer is a FIFO-ordered pair (head/skid). m_data always shows the head.
- Push and pop in the same cycle: occ is unchanged and the order is preserved.
- Capacity never exceeds 2. Overflow is impossible by construction; the bench checks it with an assertion.

Latency:
- FIFO non-empty, output idle, en=1, m_ready=1.
- m_valid rises 1 cycle after the rd_en cycle when FWFT_EN=1, and 2 cycles after when FWFT_EN=0.
- Steady-state throughput is 1 beat/clk in both modes.

Stream rules:
- While m_valid & ~m_ready: m_data and m_last hold stable and m_valid stays high.
- m_valid falls only after a pop leaves occ = 0.

Burst framing:
- m_last = m_valid & (beat_cnt == BURST_LEN-1).
- On pop: beat_cnt increments; if m_last was high, beat_cnt wraps to 0 and burst_done pulses high in the next cycle.
- BURST_LEN = 1: m_last is high on every beat.
- Framing is beat-based only. An empty FIFO mid-burst stalls m_valid and does not terminate the burst.

en deasserted mid-burst:
- No new reads are issued.
- Any in-flight word is still captured, and the buffer drains normally.
- beat_cnt is kept and resumes when en returns.

Reset mid-operation:
- Buffer, inflight and beat_cnt are cleared.
- A word already popped from the FIFO but not yet captured is discarded. The integrating design must reset the FIFO together with this block.

Test Plan:
- FWFT_EN=0, BURST_LEN=4: preload FIFO with 0x10..0x17, m_ready=1 -> first m_valid 2 cycles after first rd_en; beats 0x10..0x17 back-to-back; m_last on 0x13 and 0x17; burst_done pulses twice.
- FWFT_EN=1, same data -> m_valid 1 cycle after first rd_en; same ordering and m_last positions; no gaps.
- Backpressure: 8 words in FIFO, m_ready toggling 1,0,0,1,... -> no word lost or duplicated; m_data stable while stalled; never more than 2 words outstanding past FIFO; fifo_rd_en low while used==2 without pop.
- Underflow: FIFO holds 2 words then empty for 5 cycles, then 2 more, BURST_LEN=4 -> m_valid drops during the gap; m_last only on the 4th word; fifo_rd_en never high with fifo_empty=1.
- en cleared while a read is in flight (FWFT_EN=0) -> in-flight word still emitted; no further rd_en; beat_cnt held (e.g. 2) and continues to 3 when en returns.
- rst pulsed for 1 cycle mid-burst with occ=2 -> next cycle m_valid=0, beat_cnt=0, m_last=0, burst_done=0; reads resume with the next FIFO word as beat 0.
